// File: rtl/bp_cfg_boot_sequencer.sv
// bp_cfg_boot_sequencer
// Boot-time configuration walker. After a start request it visits every core
// and writes freeze=1, core id, CCE mode and boot PC over the config bus, then
// writes freeze=0 to every core. The config bus belongs to this block alone
// while busy_o is high. Every output is driven straight from a register.
module bp_cfg_boot_sequencer #(
  parameter int num_core_p       = 1,
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter logic [cfg_addr_width_p-1:0] freeze_addr_p   = 'h0,
  parameter logic [cfg_addr_width_p-1:0] core_id_addr_p  = 'h1,
  parameter logic [cfg_addr_width_p-1:0] cce_mode_addr_p = 'h2,
  parameter logic [cfg_addr_width_p-1:0] npc_addr_p      = 'h3
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic [cfg_data_width_p-1:0] cce_mode_i,
  input  logic [cfg_data_width_p-1:0] boot_pc_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  // A single-core configuration still gets a one-bit core counter.
  localparam int CoreCntW = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CFG      = 2'd1;
  localparam logic [1:0] ST_UNFREEZE = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  logic [1:0]                  r_state;
  logic [CoreCntW-1:0]         r_core_cnt;
  logic [1:0]                  r_reg_cnt;
  logic [cfg_data_width_p-1:0] r_mode;
  logic [cfg_data_width_p-1:0] r_pc;
  logic                        r_v;
  logic [cfg_core_width_p-1:0] r_core;
  logic [cfg_addr_width_p-1:0] r_addr;
  logic [cfg_data_width_p-1:0] r_data;
  logic                        r_busy;
  logic                        r_done;

  logic                        w_accept;
  logic                        w_last_core;
  logic                        w_last_reg;
  logic [CoreCntW-1:0]         w_core_inc;
  logic [CoreCntW-1:0]         w_next_core;
  logic [1:0]                  w_next_reg;
  logic [cfg_addr_width_p-1:0] w_next_addr;
  logic [cfg_data_width_p-1:0] w_next_data;

  // Work out which write the CFG walk presents after the current one is accepted.
  always_comb begin
    w_accept    = r_v & cfg_ready_i;
    w_last_core = (r_core_cnt == CoreCntW'(num_core_p - 1));
    w_last_reg  = (r_reg_cnt == 2'd3);
    w_core_inc  = r_core_cnt + CoreCntW'(1);
    w_next_core = r_core_cnt;
    w_next_reg  = 2'd0;
    w_next_addr = freeze_addr_p;
    w_next_data = cfg_data_width_p'(1);
    if (!w_last_reg) begin
      w_next_reg = r_reg_cnt + 2'd1;
    end else if (!w_last_core) begin
      w_next_core = w_core_inc;
    end
    case (w_next_reg)
      2'd0: begin
        w_next_addr = freeze_addr_p;
        w_next_data = cfg_data_width_p'(1);
      end
      2'd1: begin
        w_next_addr = core_id_addr_p;
        w_next_data = cfg_data_width_p'(w_next_core);
      end
      2'd2: begin
        w_next_addr = cce_mode_addr_p;
        w_next_data = r_mode;
      end
      default: begin
        w_next_addr = npc_addr_p;
        w_next_data = r_pc;
      end
    endcase
  end

  // Sequence state, counters and registered bus outputs; a reset aborts at once.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state    <= ST_IDLE;
      r_core_cnt <= '0;
      r_reg_cnt  <= '0;
      r_mode     <= '0;
      r_pc       <= '0;
      r_v        <= 1'b0;
      r_core     <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_mode     <= cce_mode_i;
            r_pc       <= boot_pc_i;
            r_core_cnt <= '0;
            r_reg_cnt  <= '0;
            r_state    <= ST_CFG;
            r_v        <= 1'b1;
            r_core     <= '0;
            r_addr     <= freeze_addr_p;
            r_data     <= cfg_data_width_p'(1);
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        ST_CFG: begin
          if (w_accept) begin
            if (w_last_reg && w_last_core) begin
              r_state    <= ST_UNFREEZE;
              r_core_cnt <= '0;
              r_reg_cnt  <= '0;
              r_core     <= '0;
              r_addr     <= freeze_addr_p;
              r_data     <= '0;
            end else begin
              r_core_cnt <= w_next_core;
              r_reg_cnt  <= w_next_reg;
              r_core     <= cfg_core_width_p'(w_next_core);
              r_addr     <= w_next_addr;
              r_data     <= w_next_data;
            end
          end
        end
        ST_UNFREEZE: begin
          if (w_accept) begin
            if (w_last_core) begin
              r_state    <= ST_DONE;
              r_core_cnt <= '0;
              r_v        <= 1'b0;
              r_core     <= '0;
              r_addr     <= '0;
              r_data     <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_core_cnt <= w_core_inc;
              r_core     <= cfg_core_width_p'(w_core_inc);
              r_addr     <= freeze_addr_p;
              r_data     <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_v_o    = r_v;
  assign cfg_core_o = r_core;
  assign cfg_addr_o = r_addr;
  assign cfg_data_o = r_data;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// tb_bp_cfg_boot_sequencer
// Drives a two-core and a one-core sequencer and compares every accepted
// config write with a list of writes built from the boot-order rules.
module tb_bp_cfg_boot_sequencer;

  localparam logic [15:0] FreezeAddr = 16'h0;
  localparam logic [15:0] CoreIdAddr = 16'h1;
  localparam logic [15:0] ModeAddr   = 16'h2;
  localparam logic [15:0] NpcAddr    = 16'h3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN, start, ready, v, busy, done;
  logic [31:0] mode, pc, data;
  logic [7:0]  core;
  logic [15:0] addr;

  logic        rstNOne, startOne, readyOne, vOne, busyOne, doneOne;
  logic [31:0] modeOne, pcOne, dataOne;
  logic [7:0]  coreOne;
  logic [15:0] addrOne;

  int checks = 0;
  int passes = 0;
  int writes = 0;
  logic [55:0] expQ[$];

  bp_cfg_boot_sequencer #(.num_core_p(2)) dutTwo (
    .clk_i(clk), .reset_n_i(rstN), .start_i(start), .cce_mode_i(mode), .boot_pc_i(pc),
    .cfg_v_o(v), .cfg_ready_i(ready), .cfg_core_o(core), .cfg_addr_o(addr),
    .cfg_data_o(data), .busy_o(busy), .done_o(done)
  );

  bp_cfg_boot_sequencer #(.num_core_p(1)) dutOne (
    .clk_i(clk), .reset_n_i(rstNOne), .start_i(startOne), .cce_mode_i(modeOne), .boot_pc_i(pcOne),
    .cfg_v_o(vOne), .cfg_ready_i(readyOne), .cfg_core_o(coreOne), .cfg_addr_o(addrOne),
    .cfg_data_o(dataOne), .busy_o(busyOne), .done_o(doneOne)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Reference write order: four writes per core, then freeze=0 to each core.
  task automatic buildExpected(input int n, input logic [31:0] m, input logic [31:0] p);
    expQ.delete();
    for (int c = 0; c < n; c++) begin
      expQ.push_back({8'(c), FreezeAddr, 32'd1});
      expQ.push_back({8'(c), CoreIdAddr, 32'(c)});
      expQ.push_back({8'(c), ModeAddr, m});
      expQ.push_back({8'(c), NpcAddr, p});
    end
    for (int c = 0; c < n; c++) expQ.push_back({8'(c), FreezeAddr, 32'd0});
  endtask

  // One cycle on the two-core DUT; mode/pc wander to prove they were latched.
  task automatic applyStimulus(input logic st, input logic rdy);
    logic [55:0] obs;
    logic [56:0] snap;
    logic        holdPending;
    start = st;
    ready = rdy;
    mode  = $urandom;
    pc    = $urandom;
    obs   = {core, addr, data};
    if (v && rdy) begin
      if (expQ.size() == 0) checkOutput("extra_write", 64'(expQ.size()), 64'd1);
      else checkOutput("write", 64'(obs), 64'(expQ.pop_front()));
      writes++;
    end
    holdPending = v && !rdy;
    snap = {v, obs};
    @(posedge clk); #1;
    if (holdPending) checkOutput("hold_stable", 64'({v, core, addr, data}), 64'(snap));
    checkOutput("busy_done_excl", 64'(busy & done), 64'd0);
  endtask

  task automatic runSeq(input logic randReady, input logic startHold, input logic [31:0] m, input logic [31:0] p);
    int cycles;
    buildExpected(2, m, p);
    mode  = m;
    pc    = p;
    start = 1'b1;
    ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    checkOutput("start_latency", 64'({v, busy, done, core, addr, data}),
                64'({1'b1, 1'b1, 1'b0, 8'd0, FreezeAddr, 32'd1}));
    writes = 0;
    cycles = 0;
    while (!done && cycles < 200) begin
      applyStimulus(startHold, randReady ? 1'($urandom_range(0, 1)) : 1'b1);
      cycles++;
    end
    start = 1'b0;
    checkOutput("done_state", 64'({done, busy, v}), 64'(3'b100));
    checkOutput("write_count", 64'(writes), 64'd10);
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    if (!randReady) checkOutput("b2b_cycles", 64'(cycles), 64'd10);
  endtask

  initial begin
    logic [55:0] oneExp[5];
    logic [31:0] m1, p1;
    rstN = 1'b0; start = 1'b0; ready = 1'b0; mode = '0; pc = '0;
    rstNOne = 1'b0; startOne = 1'b0; readyOne = 1'b0; modeOne = '0; pcOne = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_two", 64'({v, busy, done, core, addr, data}), 64'd0);
    checkOutput("reset_one", 64'({vOne, busyOne, doneOne, coreOne, addrOne, dataOne}), 64'd0);
    rstN = 1'b1;
    rstNOne = 1'b1;
    applyStimulus(1'b0, 1'b1);

    $display("[TB] back-to-back sequence");
    runSeq(1'b0, 1'b0, 32'd3, 32'h8000_0000);
    $display("[TB] random ready");
    runSeq(1'b1, 1'b0, $urandom, $urandom);
    runSeq(1'b1, 1'b0, $urandom, $urandom);
    $display("[TB] start held during sequence, then restart from DONE");
    runSeq(1'b1, 1'b1, $urandom, $urandom);
    runSeq(1'b0, 1'b1, $urandom, $urandom);

    $display("[TB] reset after fourth accept");
    buildExpected(2, 32'h1234_5678, 32'h0000_4000);
    mode = 32'h1234_5678; pc = 32'h0000_4000; start = 1'b1;
    @(posedge clk); #1;
    repeat (4) applyStimulus(1'b0, 1'b1);
    rstN = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_reset", 64'({v, busy, done, core, addr, data}), 64'd0);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkOutput("idle_after_reset", 64'({v, busy, done}), 64'd0);
    runSeq(1'b0, 1'b0, $urandom, $urandom);

    $display("[TB] single core with stalled ready");
    m1 = $urandom; p1 = $urandom;
    oneExp[0] = {8'd0, FreezeAddr, 32'd1};
    oneExp[1] = {8'd0, CoreIdAddr, 32'd0};
    oneExp[2] = {8'd0, ModeAddr, m1};
    oneExp[3] = {8'd0, NpcAddr, p1};
    oneExp[4] = {8'd0, FreezeAddr, 32'd0};
    modeOne = m1; pcOne = p1; startOne = 1'b1; readyOne = 1'b0;
    @(posedge clk); #1;
    startOne = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checkOutput("one_stall", 64'({vOne, busyOne, coreOne, addrOne, dataOne}),
                  64'({1'b1, 1'b1, 8'd0, FreezeAddr, 32'd1}));
      modeOne = $urandom; pcOne = $urandom;
      @(posedge clk); #1;
    end
    readyOne = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("one_write", 64'({vOne, coreOne, addrOne, dataOne}), 64'({1'b1, oneExp[i]}));
      @(posedge clk); #1;
    end
    checkOutput("one_done", 64'({doneOne, busyOne, vOne}), 64'(3'b100));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
